// File: rtl/circular_buffer.sv
// Per-virtual-channel flit FIFO: ring buffer with a registered pop output and a
// combinational head view. It supports any depth >= 2, so the pointers wrap explicitly.
module circular_buffer #(
  parameter int BUFFER_SIZE = 4,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  write_i,
  input  logic                  read_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [DATA_WIDTH-1:0] peek_o,
  output logic                  is_full,
  output logic                  is_empty
);

  localparam int PTR_W = $clog2(BUFFER_SIZE);
  localparam int CNT_W = $clog2(BUFFER_SIZE + 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(BUFFER_SIZE - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUFFER_SIZE);

  logic [DATA_WIDTH-1:0] mem_q [BUFFER_SIZE];
  logic [DATA_WIDTH-1:0] mem_d [BUFFER_SIZE];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  write_ok, read_ok;

  assign is_full  = (count_q == FULL_CNT);
  assign is_empty = (count_q == '0);
  assign peek_o   = mem_q[rd_ptr_q];
  assign data_o   = data_q;

  // A read frees a slot on the same edge, so a full buffer can still accept a write.
  assign read_ok  = read_i && !is_empty;
  assign write_ok = write_i && (!is_full || read_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    data_d   = data_q;

    if (write_ok) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
    end

    if (read_ok) begin
      data_d   = mem_q[rd_ptr_q];
      rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + 1'b1;
    end

    case ({write_ok, read_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUFFER_SIZE; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
    end else begin
      for (int i = 0; i < BUFFER_SIZE; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
    end
  end

endmodule

// File: tb/tb_circular_buffer.sv
// Self-checking bench for circular_buffer (depth 4): directed scenarios plus a random
// run, all compared against a queue-based FIFO model.
module tb_circular_buffer;

  localparam int DEPTH = 4;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data_i;
  logic          write_i;
  logic          read_i;
  logic [DW-1:0] data_o;
  logic [DW-1:0] peek_o;
  logic          is_full;
  logic          is_empty;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] model_q [$];
  logic [DW-1:0] exp_out;

  localparam logic [DW-1:0] VA = 32'hA000_000A, VB = 32'hB000_000B, VC = 32'hC000_000C,
                            VD = 32'hD000_000D, VE = 32'hE000_000E, VF = 32'hF000_000F,
                            VG = 32'h6000_0006, VH = 32'h7000_0007;

  circular_buffer #(.BUFFER_SIZE(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_i   (data_i),
    .write_i  (write_i),
    .read_i   (read_i),
    .data_o   (data_o),
    .peek_o   (peek_o),
    .is_full  (is_full),
    .is_empty (is_empty)
  );

  always #5 clk = ~clk;

  // Drives one clock cycle and advances the reference FIFO by the same rules.
  task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d);
    bit rd_ok, wr_ok;
    write_i = w;
    read_i  = r;
    data_i  = d;
    @(posedge clk);
    rd_ok = r && (model_q.size() > 0);
    wr_ok = w && ((model_q.size() < DEPTH) || rd_ok);
    if (rd_ok) exp_out = model_q.pop_front();
    if (wr_ok) model_q.push_back(d);
    #1;
    write_i = 1'b0;
    read_i  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, '0);
    model_q.delete();
    exp_out = '0;
    rst = 1'b0;
    #2;
    total++; if (is_empty !== 1'b1) begin bad++; $display("[TB] FAIL reset_empty: got %b want 1", is_empty); end
    total++; if (is_full !== 1'b0) begin bad++; $display("[TB] FAIL reset_full: got %b want 0", is_full); end
    total++; if (data_o !== '0) begin bad++; $display("[TB] FAIL reset_data: got %h want 0", data_o); end
    total++; if (peek_o !== '0) begin bad++; $display("[TB] FAIL reset_peek: got %h want 0", peek_o); end
  endtask

  task automatic test_fill();
    cycle(1'b1, 1'b0, VA);
    cycle(1'b1, 1'b0, VB);
    cycle(1'b1, 1'b0, VC);
    cycle(1'b1, 1'b0, VD);
    total++; if (is_full !== 1'b1) begin bad++; $display("[TB] FAIL fill_full: got %b want 1", is_full); end
    total++; if (is_empty !== 1'b0) begin bad++; $display("[TB] FAIL fill_empty: got %b want 0", is_empty); end
    total++; if (peek_o !== VA) begin bad++; $display("[TB] FAIL fill_peek: got %h want %h", peek_o, VA); end
  endtask

  task automatic test_read_pulses();
    cycle(1'b0, 1'b1, '0);
    total++; if (data_o !== VA) begin bad++; $display("[TB] FAIL read1_data: got %h want %h", data_o, VA); end
    cycle(1'b0, 1'b1, '0);
    total++; if (data_o !== VB) begin bad++; $display("[TB] FAIL read2_data: got %h want %h", data_o, VB); end
    total++; if (peek_o !== VC) begin bad++; $display("[TB] FAIL read2_peek: got %h want %h", peek_o, VC); end
    total++; if (is_full !== 1'b0 || is_empty !== 1'b0) begin bad++; $display("[TB] FAIL read2_flags: got full=%b empty=%b want 0 0", is_full, is_empty); end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] seq [4];
    seq = '{VC, VD, VE, VF};
    cycle(1'b1, 1'b0, VE);
    cycle(1'b1, 1'b0, VF);
    total++; if (is_full !== 1'b1) begin bad++; $display("[TB] FAIL wrap_full: got %b want 1", is_full); end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, '0);
      total++; if (data_o !== seq[i]) begin bad++; $display("[TB] FAIL wrap_read%0d: got %h want %h", i, data_o, seq[i]); end
    end
    total++; if (is_empty !== 1'b1) begin bad++; $display("[TB] FAIL wrap_empty: got %b want 1", is_empty); end
  endtask

  task automatic test_ignored();
    logic [DW-1:0] held;
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 32'h1000_0000 + DW'(i));
    cycle(1'b1, 1'b0, VG);
    total++; if (is_full !== 1'b1) begin bad++; $display("[TB] FAIL drop_full: got %b want 1", is_full); end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 1'b1, '0);
      total++; if (data_o !== 32'h1000_0000 + DW'(i)) begin bad++; $display("[TB] FAIL drop_read%0d: got %h want %h", i, data_o, 32'h1000_0000 + DW'(i)); end
    end
    total++; if (is_empty !== 1'b1) begin bad++; $display("[TB] FAIL drop_empty: got %b want 1", is_empty); end
    held = data_o;
    cycle(1'b0, 1'b1, '0);
    total++; if (data_o !== held) begin bad++; $display("[TB] FAIL empty_read_hold: got %h want %h", data_o, held); end
    total++; if (is_empty !== 1'b1) begin bad++; $display("[TB] FAIL empty_read_flag: got %b want 1", is_empty); end
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 32'h2000_0000 + DW'(i));
    cycle(1'b1, 1'b1, 32'h2000_0004);
    total++; if (data_o !== 32'h2000_0000) begin bad++; $display("[TB] FAIL rw_full_data: got %h want 20000000", data_o); end
    total++; if (is_full !== 1'b1) begin bad++; $display("[TB] FAIL rw_full_flag: got %b want 1", is_full); end
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b0, 1'b1, '0);
      total++; if (data_o !== 32'h2000_0000 + DW'(i)) begin bad++; $display("[TB] FAIL rw_order%0d: got %h want %h", i, data_o, 32'h2000_0000 + DW'(i)); end
    end
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 1'b0, VA);
    cycle(1'b1, 1'b0, VB);
    cycle(1'b1, 1'b0, VC);
    #2;
    rst = 1'b1;
    #1;
    model_q.delete();
    exp_out = '0;
    total++; if (is_empty !== 1'b1) begin bad++; $display("[TB] FAIL async_empty: got %b want 1", is_empty); end
    total++; if (data_o !== '0) begin bad++; $display("[TB] FAIL async_data: got %h want 0", data_o); end
    total++; if (peek_o !== '0) begin bad++; $display("[TB] FAIL async_peek: got %h want 0", peek_o); end
    #1;
    rst = 1'b0;
    cycle(1'b1, 1'b0, VH);
    cycle(1'b0, 1'b1, '0);
    total++; if (data_o !== VH) begin bad++; $display("[TB] FAIL async_after_h: got %h want %h", data_o, VH); end
  endtask

  task automatic test_random();
    logic          w, r;
    logic [DW-1:0] d;
    for (int n = 0; n < 400; n++) begin
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      d = $urandom;
      cycle(w, r, d);
      total++; if (data_o !== exp_out) begin bad++; $display("[TB] FAIL rand_data@%0d: got %h want %h", n, data_o, exp_out); end
      total++; if (is_full !== (model_q.size() == DEPTH)) begin bad++; $display("[TB] FAIL rand_full@%0d: got %b want %b", n, is_full, model_q.size() == DEPTH); end
      total++; if (is_empty !== (model_q.size() == 0)) begin bad++; $display("[TB] FAIL rand_empty@%0d: got %b want %b", n, is_empty, model_q.size() == 0); end
      if (model_q.size() > 0) begin
        total++; if (peek_o !== model_q[0]) begin bad++; $display("[TB] FAIL rand_peek@%0d: got %h want %h", n, peek_o, model_q[0]); end
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    write_i = 1'b0;
    read_i  = 1'b0;
    data_i  = '0;
    exp_out = '0;
    test_reset();
    test_fill();
    test_read_pulses();
    test_wrap();
    test_ignored();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
